alu_nway_seq: RTL and testbench

- Parametrised, registered successor to the 4-bit combinational ALU, for the exp-series datapath.
- Adds the following over that ALU:
  - WIDTH generalisation.
  - Shifts and unsigned compare.
  - Iterative multi-cycle multiply.
  - valid/ready handshakes on both sides.
  - Flags registered alongside the result.
- Sits between operand source (regfile/decoder) and writeback; one operation in flight at a time.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/addsub_nway.sv | 25 ++
 rtl/alu_nway_seq.sv | 153 +++++++++++++++
 tb/tb_alu_nway_seq.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state definitions for the sequential n-way ALU
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_SLTU = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

endpackage

// File: rtl/addsub_nway.sv
// rtl/addsub_nway.sv - shared combinational adder/subtractor with carry/borrow and overflow
module addsub_nway #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cf,
  output logic             of
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  assign b_eff = sub ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign sum   = full[WIDTH-1:0];

  // Subtract reports borrow, i.e. inverted carry-out, so cf means a < b unsigned.
  assign cf = sub ? ~full[WIDTH] : full[WIDTH];
  assign of = sub ? ((a[WIDTH-1] != b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]))
                  : ((a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]));

endmodule

// File: rtl/alu_nway_seq.sv
// rtl/alu_nway_seq.sv - registered WIDTH-bit ALU with valid/ready handshakes
// and an iterative shift-add multiplier; one operation in flight at a time.
module alu_nway_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cf,
  output logic             of,
  output logic             zf
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cf_q, cf_d, of_q, of_d, zf_q, zf_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mult_q, mult_d, acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             as_sub, as_cf, as_of;
  logic [WIDTH-1:0] as_sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res, acc_n;
  logic             res_cf, res_of, accept;

  assign as_sub = (sel != OP_ADD);
  assign shamt  = b[SHW-1:0];

  addsub_nway #(.WIDTH(WIDTH)) u_addsub (
    .a   (a),
    .b   (b),
    .sub (as_sub),
    .sum (as_sum),
    .cf  (as_cf),
    .of  (as_of)
  );

  always_comb begin
    res    = '0;
    res_cf = 1'b0;
    res_of = 1'b0;
    case (sel)
      OP_ADD, OP_SUB: begin
        res    = as_sum;
        res_cf = as_cf;
        res_of = as_of;
      end
      OP_NOT:  res = ~a;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_of};
      OP_EQ:   res = {{(WIDTH-1){1'b0}}, a == b};
      OP_SLL:  res = a << shamt;
      OP_SRL:  res = a >> shamt;
      OP_SRA:  res = $signed(a) >>> shamt;
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, as_cf};
      default: ;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid & in_ready;
  assign acc_n     = acc_q + (mult_q[0] ? mcand_q : '0);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cf_d    = cf_q;
    of_d    = of_q;
    zf_d    = zf_q;
    mcand_d = mcand_q;
    mult_d  = mult_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_BUSY: begin
        mcand_d = mcand_q << 1;
        mult_d  = mult_q >> 1;
        acc_d   = acc_n;
        cnt_d   = cnt_q - CW'(1);
        // Last partial product is folded straight into out: WIDTH+1 cycle latency.
        if (cnt_q == CW'(1)) begin
          out_d   = acc_n;
          cf_d    = 1'b0;
          of_d    = 1'b0;
          zf_d    = (acc_n == '0);
          state_d = S_DONE;
        end
      end
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: ;
    endcase
    if (accept) begin
      if (sel == OP_MUL) begin
        mcand_d = a;
        mult_d  = b;
        acc_d   = '0;
        cnt_d   = CW'(WIDTH);
        state_d = S_BUSY;
      end else begin
        out_d   = res;
        cf_d    = res_cf;
        of_d    = res_of;
        zf_d    = (res == '0);
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      cf_q    <= 1'b0;
      of_q    <= 1'b0;
      zf_q    <= 1'b0;
      mcand_q <= '0;
      mult_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cf_q    <= cf_d;
      of_q    <= of_d;
      zf_q    <= zf_d;
      mcand_q <= mcand_d;
      mult_q  <= mult_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out = out_q;
  assign cf  = cf_q;
  assign of  = of_q;
  assign zf  = zf_q;

endmodule

// File: tb/tb_alu_nway_seq.sv
// tb/tb_alu_nway_seq.sv - scoreboard bench for alu_nway_seq at WIDTH=8
module tb_alu_nway_seq;

  typedef struct packed {
    logic [7:0] out;
    logic       cf;
    logic       of;
    logic       zf;
  } res_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, out;
  logic [3:0] sel;
  logic       cf, of, zf;

  int   tests = 0;
  int   fails = 0;
  res_t sb[$];

  always #5 clk = ~clk;

  alu_nway_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .cf        (cf),
    .of        (of),
    .zf        (zf)
  );

  function automatic res_t model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    res_t r;
    logic [8:0] s;
    r = '0;
    case (op)
      4'd0: begin
        s = {1'b0, x} + {1'b0, y};
        r.out = s[7:0];
        r.cf = s[8];
        r.of = (x[7] == y[7]) && (s[7] != x[7]);
      end
      4'd1: begin
        r.out = x - y;
        r.cf = (x < y);
        r.of = (x[7] != y[7]) && (r.out[7] != x[7]);
      end
      4'd2:  r.out = ~x;
      4'd3:  r.out = x & y;
      4'd4:  r.out = x | y;
      4'd5:  r.out = x ^ y;
      4'd6:  r.out = ($signed(x) < $signed(y)) ? 8'd1 : 8'd0;
      4'd7:  r.out = (x == y) ? 8'd1 : 8'd0;
      4'd8:  r.out = x << y[2:0];
      4'd9:  r.out = x >> y[2:0];
      4'd10: r.out = 8'($signed(x) >>> y[2:0]);
      4'd11: r.out = 8'(x * y);
      4'd12: r.out = (x < y) ? 8'd1 : 8'd0;
      default: r.out = 8'd0;
    endcase
    r.zf = (r.out == 8'd0);
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    int n;
    n = 0;
    sel = op; a = x; b = y; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end else begin
      sb.push_back(model(op, x, y));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic get_result(output res_t r, output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) begin
      tests++; fails++;
      $display("FAIL result_timeout: out_valid=%b required 1", out_valid);
    end
    r = {out, cf, of, zf};
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sel = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({out_valid, in_ready, out, cf, of, zf} !== {1'b0, 1'b1, 8'h00, 3'b000}) begin
      fails++;
      $display("FAIL reset_state: got v=%b r=%b out=%h f=%b%b%b required v=0 r=1 out=00 f=000",
               out_valid, in_ready, out, cf, of, zf);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({out_valid, out, cf, of, zf} !== {1'b0, 8'h00, 3'b000}) begin
      fails++;
      $display("FAIL reset_idle_hold: got v=%b out=%h f=%b%b%b required v=0 out=00 f=000",
               out_valid, out, cf, of, zf);
    end
  endtask

  task automatic test_add;
    res_t r, e;
    int lat;
    send(4'd0, 8'h7F, 8'h01);
    get_result(r, lat);
    e = sb.pop_front();
    tests++;
    if (r !== e || r.out !== 8'h80 || r.of !== 1'b1 || r.cf !== 1'b0 || r.zf !== 1'b0) begin
      fails++;
      $display("FAIL add_7f_01: got %h required %h", r, e);
    end
    tests++;
    if (lat !== 1) begin
      fails++;
      $display("FAIL add_latency: got %0d required 1", lat);
    end
  endtask

  task automatic test_sub_cmp;
    logic [3:0] ops[4] = '{4'd1, 4'd1, 4'd6, 4'd12};
    logic [7:0] xs[4]  = '{8'h05, 8'h03, 8'hFF, 8'hFF};
    logic [7:0] ys[4]  = '{8'h05, 8'h05, 8'h01, 8'h01};
    logic [7:0] exo[4] = '{8'h00, 8'hFE, 8'h01, 8'h00};
    res_t r, e;
    int lat;
    for (int i = 0; i < 4; i++) begin
      send(ops[i], xs[i], ys[i]);
      get_result(r, lat);
      e = sb.pop_front();
      tests++;
      if (r !== e || r.out !== exo[i]) begin
        fails++;
        $display("FAIL sub_cmp_%0d: got %h required %h (out %h)", i, r, e, exo[i]);
      end
    end
  endtask

  task automatic test_mul;
    res_t r, e;
    int lat;
    bit busy_ok;
    send(4'd11, 8'h0D, 8'h0B);
    lat = 1; busy_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      if (lat == 3) begin
        in_valid = 1'b1; sel = 4'd0; a = 8'h01; b = 8'h01;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    r = {out, cf, of, zf};
    e = sb.pop_front();
    tests++;
    if (r !== e || r.out !== 8'h8F) begin
      fails++;
      $display("FAIL mul_0d_0b: got %h required %h", r, e);
    end
    tests++;
    if (lat !== 9) begin
      fails++;
      $display("FAIL mul_latency: got %0d required 9", lat);
    end
    tests++;
    if (!busy_ok) begin
      fails++;
      $display("FAIL mul_busy_ready: in_ready got 1 required 0");
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL mul_busy_drop: out_valid got %b required 0", out_valid);
    end
  endtask

  task automatic test_shifts;
    logic [3:0] ops[4] = '{4'd10, 4'd9, 4'd8, 4'd14};
    logic [7:0] xs[4]  = '{8'h90, 8'h90, 8'h81, 8'h5A};
    logic [7:0] ys[4]  = '{8'h03, 8'h03, 8'h01, 8'hA5};
    logic [7:0] exo[4] = '{8'hF2, 8'h12, 8'h02, 8'h00};
    res_t r, e;
    int lat;
    for (int i = 0; i < 4; i++) begin
      send(ops[i], xs[i], ys[i]);
      get_result(r, lat);
      e = sb.pop_front();
      tests++;
      if (r !== e || r.out !== exo[i]) begin
        fails++;
        $display("FAIL shift_rsv_%0d: got %h required %h (out %h)", i, r, e, exo[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    res_t held, e;
    bit ok;
    out_ready = 1'b0;
    send(4'd0, 8'hC0, 8'h50);
    held = {out, cf, of, zf};
    e = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1 || held !== e) begin
      fails++;
      $display("FAIL bp_add: got v=%b %h required v=1 %h", out_valid, held, e);
    end
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out, cf, of, zf} !== held) ok = 1'b0;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL bp_hold: got v=%b r=%b %h required v=1 r=0 %h",
               out_valid, in_ready, {out, cf, of, zf}, held);
    end
    out_ready = 1'b1;
    send(4'd5, 8'hF0, 8'h3C);
    e = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1 || {out, cf, of, zf} !== e || out !== 8'hCC) begin
      fails++;
      $display("FAIL b2b_xor: got v=%b %h required v=1 %h", out_valid, {out, cf, of, zf}, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul;
    res_t r, e;
    int lat;
    send(4'd11, 8'hFF, 8'hFF);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    void'(sb.pop_back());
    tests++;
    if ({out_valid, in_ready, out, cf, of, zf} !== {1'b0, 1'b1, 8'h00, 3'b000}) begin
      fails++;
      $display("FAIL rst_mid_mul: got v=%b r=%b out=%h f=%b%b%b required v=0 r=1 out=00 f=000",
               out_valid, in_ready, out, cf, of, zf);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    send(4'd0, 8'h01, 8'h01);
    get_result(r, lat);
    e = sb.pop_front();
    tests++;
    if (r !== e || r.out !== 8'h02) begin
      fails++;
      $display("FAIL post_rst_add: got %h required %h", r, e);
    end
  endtask

  task automatic test_random;
    res_t r, e;
    int lat;
    logic [3:0] op;
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15));
      send(op, 8'($urandom), 8'($urandom));
      get_result(r, lat);
      e = sb.pop_front();
      tests++;
      if (r !== e || lat !== ((op == 4'd11) ? 9 : 1)) begin
        fails++;
        $display("FAIL random_%0d op=%0d: got %h lat %0d required %h lat %0d",
                 i, op, r, lat, e, (op == 4'd11) ? 9 : 1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_sub_cmp();
    test_mul();
    test_shifts();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
